// File: rtl/acc_ctrl.sv
// Accumulator control sequencer driving the op/operand side of an 8-bit ALU.
// Latency: ALU op accepted at edge n writes back at n+1; STA raises store valid the cycle after accept.
// Backpressure: instruction ready only in IDLE; store holds valid/data/cy stable until IN_ST_READY is sampled.
//
// Ports:
//   CLK, RST_N                        clock (rising edge), asynchronous active-low reset
//   IN_INSTR_VALID/IN_INSTR           instruction channel {op[2:0], imm[DATA_W-1:0]}
//   OUT_INSTR_READY                   instruction accept (high in IDLE)
//   OUT_ALU_A/OUT_ALU_R/OUT_ALU_OP    ALU operands and opcode (111 = idle, ALU outputs 0)
//   IN_ALU_RES/IN_ALU_CY              ALU result and carry/borrow
//   OUT_ST_VALID/OUT_ST_DATA/OUT_ST_CY/IN_ST_READY   store channel
//   OUT_ACC, OUT_CY, OUT_RETIRED      architectural state and retired-instruction count
//   OUT_Z                             zero flag, present only when ACC_CTRL_ZERO_FLAG_EN is defined
//
// Build option: define ACC_CTRL_ZERO_FLAG_EN to add the zero flag register and OUT_Z port.

module acc_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_INSTR_VALID,
    input  logic [DATA_W+2:0] IN_INSTR,
    output logic              OUT_INSTR_READY,
    output logic [DATA_W-1:0] OUT_ALU_A,
    output logic [DATA_W-1:0] OUT_ALU_R,
    output logic [2:0]        OUT_ALU_OP,
    input  logic [DATA_W-1:0] IN_ALU_RES,
    input  logic              IN_ALU_CY,
    output logic              OUT_ST_VALID,
    output logic [DATA_W-1:0] OUT_ST_DATA,
    output logic              OUT_ST_CY,
    input  logic              IN_ST_READY,
    output logic [DATA_W-1:0] OUT_ACC,
    output logic              OUT_CY,
`ifdef ACC_CTRL_ZERO_FLAG_EN
    output logic              OUT_Z,
`endif
    output logic [7:0]        OUT_RETIRED
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_STA = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        STORE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_acc;
    logic              r_cy;
    logic [7:0]        r_retired;
    logic              w_accept;
    logic [2:0]        w_instr_op;

    assign w_instr_op = IN_INSTR[DATA_W+2:DATA_W];
    assign w_accept   = (r_state == IDLE) && IN_INSTR_VALID;

    // Next-state and output decode
    always_comb begin
        w_next_state    = r_state;
        OUT_INSTR_READY = 1'b0;
        OUT_ALU_OP      = OP_STA;
        OUT_ST_VALID    = 1'b0;
        case (r_state)
            IDLE: begin
                OUT_INSTR_READY = 1'b1;
                if (IN_INSTR_VALID) begin
                    w_next_state = (w_instr_op == OP_STA) ? STORE : EXEC;
                end
            end
            EXEC: begin
                OUT_ALU_OP   = r_op;
                w_next_state = IDLE;
            end
            STORE: begin
                OUT_ST_VALID = 1'b1;
                if (IN_ST_READY) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Instruction latch, writeback and retire counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_op      <= '0;
            r_imm     <= '0;
            r_acc     <= '0;
            r_cy      <= 1'b0;
            r_retired <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= w_instr_op;
                r_imm <= IN_INSTR[DATA_W-1:0];
            end
            if (r_state == EXEC) begin
                r_acc     <= IN_ALU_RES;
                r_retired <= r_retired + 8'd1;
                // Only arithmetic ops define carry; logic ops and LD leave it alone.
                if (r_op == OP_ADD || r_op == OP_SUB) begin
                    r_cy <= IN_ALU_CY;
                end
            end
            if (r_state == STORE && IN_ST_READY) begin
                r_retired <= r_retired + 8'd1;
            end
        end
    end

`ifdef ACC_CTRL_ZERO_FLAG_EN
    logic r_z;

    // Zero tracks every ALU writeback, including LD; stores leave it alone.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_z <= 1'b0;
        end else if (r_state == EXEC) begin
            r_z <= (IN_ALU_RES == '0);
        end
    end

    assign OUT_Z = r_z;
`endif

    assign OUT_ALU_A   = r_acc;
    assign OUT_ALU_R   = r_imm;
    assign OUT_ST_DATA = r_acc;
    assign OUT_ST_CY   = r_cy;
    assign OUT_ACC     = r_acc;
    assign OUT_CY      = r_cy;
    assign OUT_RETIRED = r_retired;

endmodule

// File: tb/tb_acc_ctrl.sv
// Directed bench for acc_ctrl with a behavioural 8-bit ALU attached to its op/operand ports.
// Latency: checks sample on the falling edge, half a cycle after state changes.
// Backpressure: store ready is held low for chosen cycle counts, and also raised before valid.

module tb_acc_ctrl;

    localparam int DATA_W = 8;

    logic              CLK;
    logic              RST_N;
    logic              IN_INSTR_VALID;
    logic [DATA_W+2:0] IN_INSTR;
    logic              OUT_INSTR_READY;
    logic [DATA_W-1:0] OUT_ALU_A;
    logic [DATA_W-1:0] OUT_ALU_R;
    logic [2:0]        OUT_ALU_OP;
    logic [DATA_W-1:0] IN_ALU_RES;
    logic              IN_ALU_CY;
    logic              OUT_ST_VALID;
    logic [DATA_W-1:0] OUT_ST_DATA;
    logic              OUT_ST_CY;
    logic              IN_ST_READY;
    logic [DATA_W-1:0] OUT_ACC;
    logic              OUT_CY;
    logic [7:0]        OUT_RETIRED;
`ifdef ACC_CTRL_ZERO_FLAG_EN
    logic              OUT_Z;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [2:0] exec_op_seen;

    acc_ctrl #(.DATA_W(DATA_W)) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .IN_INSTR_VALID  (IN_INSTR_VALID),
        .IN_INSTR        (IN_INSTR),
        .OUT_INSTR_READY (OUT_INSTR_READY),
        .OUT_ALU_A       (OUT_ALU_A),
        .OUT_ALU_R       (OUT_ALU_R),
        .OUT_ALU_OP      (OUT_ALU_OP),
        .IN_ALU_RES      (IN_ALU_RES),
        .IN_ALU_CY       (IN_ALU_CY),
        .OUT_ST_VALID    (OUT_ST_VALID),
        .OUT_ST_DATA     (OUT_ST_DATA),
        .OUT_ST_CY       (OUT_ST_CY),
        .IN_ST_READY     (IN_ST_READY),
        .OUT_ACC         (OUT_ACC),
        .OUT_CY          (OUT_CY),
`ifdef ACC_CTRL_ZERO_FLAG_EN
        .OUT_Z           (OUT_Z),
`endif
        .OUT_RETIRED     (OUT_RETIRED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference ALU: {cy,res} = A op R in 9 bits; opcode 111 yields zero.
    logic [DATA_W:0] alu_sum;
    always_comb begin
        alu_sum = '0;
        case (OUT_ALU_OP)
            3'b000:  alu_sum = {1'b0, OUT_ALU_A} + {1'b0, OUT_ALU_R};
            3'b001:  alu_sum = {1'b0, OUT_ALU_A} - {1'b0, OUT_ALU_R};
            3'b010:  alu_sum = {1'b0, OUT_ALU_A | OUT_ALU_R};
            3'b011:  alu_sum = {1'b0, OUT_ALU_A & OUT_ALU_R};
            3'b100:  alu_sum = {1'b0, OUT_ALU_A ^ OUT_ALU_R};
            3'b101:  alu_sum = {1'b0, ~OUT_ALU_A};
            3'b110:  alu_sum = {1'b0, OUT_ALU_R};
            default: alu_sum = '0;
        endcase
    end
    assign IN_ALU_RES = alu_sum[DATA_W-1:0];
    assign IN_ALU_CY  = alu_sum[DATA_W];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!OUT_INSTR_READY && w < 20) begin
            @(negedge CLK);
            w++;
        end
        if (w >= 20) chk("instr_ready_wait", 32'(OUT_INSTR_READY), 32'd1);
    endtask

    // One ALU instruction; junk with valid high is offered while in EXEC and must be ignored.
    task automatic do_op(input logic [2:0] op, input logic [7:0] imm);
        @(negedge CLK);
        wait_ready();
        IN_INSTR_VALID = 1'b1;
        IN_INSTR       = {op, imm};
        @(negedge CLK);
        exec_op_seen   = OUT_ALU_OP;
        IN_INSTR       = 11'($urandom);
        @(negedge CLK);
        IN_INSTR_VALID = 1'b0;
    endtask

    // STA with ready held low for 'stall' store cycles (stall==0: ready high before valid).
    task automatic do_sta(input int stall, input logic [7:0] exp_d, input logic exp_cy);
        @(negedge CLK);
        wait_ready();
        IN_ST_READY    = (stall == 0);
        IN_INSTR_VALID = 1'b1;
        IN_INSTR       = {3'b111, 8'hA5};
        @(negedge CLK);
        IN_INSTR_VALID = 1'b0;
        chk("st_valid_rise", 32'(OUT_ST_VALID), 32'd1);
        for (int i = 0; i < stall; i++) begin
            chk("st_valid_hold", 32'(OUT_ST_VALID), 32'd1);
            chk("st_data_hold", 32'(OUT_ST_DATA), 32'(exp_d));
            chk("st_cy_hold", 32'(OUT_ST_CY), 32'(exp_cy));
            chk("instr_ready_busy", 32'(OUT_INSTR_READY), 32'd0);
            chk("alu_op_store", 32'(OUT_ALU_OP), 32'd7);
            @(negedge CLK);
        end
        chk("st_data_xfer", 32'(OUT_ST_DATA), 32'(exp_d));
        IN_ST_READY = 1'b1;
        @(negedge CLK);
        chk("st_valid_drop", 32'(OUT_ST_VALID), 32'd0);
        chk("instr_ready_after_st", 32'(OUT_INSTR_READY), 32'd1);
        IN_ST_READY = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_acc"}, 32'(OUT_ACC), 32'd0);
        chk({tag, "_cy"}, 32'(OUT_CY), 32'd0);
        chk({tag, "_ret"}, 32'(OUT_RETIRED), 32'd0);
        chk({tag, "_aluop"}, 32'(OUT_ALU_OP), 32'd7);
        chk({tag, "_stv"}, 32'(OUT_ST_VALID), 32'd0);
`ifdef ACC_CTRL_ZERO_FLAG_EN
        chk({tag, "_z"}, 32'(OUT_Z), 32'd0);
`endif
    endtask

    task automatic release_reset();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("ready_after_reset", 32'(OUT_INSTR_READY), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N          = 1'b0;
        IN_INSTR_VALID = 1'b0;
        IN_INSTR       = '0;
        IN_ST_READY    = 1'b0;
        #1;
        chk_reset_state("por");
        chk("por_alu_r", 32'(OUT_ALU_R), 32'd0);
        release_reset();

        // LD 0xF0, ADD 0x20 -> 0x110: ACC=0x10, CY=1
        do_op(3'b110, 8'hF0);
        chk("ld_acc", 32'(OUT_ACC), 32'hF0);
        chk("ld_ret", 32'(OUT_RETIRED), 32'd1);
        do_op(3'b000, 8'h20);
        chk("add_exec_op", 32'(exec_op_seen), 32'd0);
        chk("add_op_after", 32'(OUT_ALU_OP), 32'd7);
        chk("add_acc", 32'(OUT_ACC), 32'h10);
        chk("add_cy", 32'(OUT_CY), 32'd1);
        chk("add_ret", 32'(OUT_RETIRED), 32'd2);
        chk("alu_r_holds", 32'(OUT_ALU_R), 32'h20);

        // Reset in the middle of an ADD: writeback is dropped
        @(negedge CLK);
        IN_INSTR_VALID = 1'b1;
        IN_INSTR       = {3'b000, 8'h01};
        @(negedge CLK);
        IN_INSTR_VALID = 1'b0;
        chk("mid_exec_op", 32'(OUT_ALU_OP), 32'd0);
        #1 RST_N = 1'b0;
        #1;
        chk_reset_state("rst_exec");
        release_reset();

        // LD 0x05, SUB 0x06 -> 0xFF with borrow; OR keeps CY; NOT -> 0x00
        do_op(3'b110, 8'h05);
        do_op(3'b001, 8'h06);
        chk("sub_acc", 32'(OUT_ACC), 32'hFF);
        chk("sub_cy", 32'(OUT_CY), 32'd1);
        do_op(3'b010, 8'h00);
        chk("or_acc", 32'(OUT_ACC), 32'hFF);
        chk("or_cy_kept", 32'(OUT_CY), 32'd1);
        do_op(3'b101, 8'h00);
        chk("not_acc", 32'(OUT_ACC), 32'h00);
        chk("not_cy_kept", 32'(OUT_CY), 32'd1);
        chk("not_ret", 32'(OUT_RETIRED), 32'd4);
`ifdef ACC_CTRL_ZERO_FLAG_EN
        chk("not_z", 32'(OUT_Z), 32'd1);
`endif

        // Store with three stalled cycles, then one with ready raised early
        do_op(3'b110, 8'hFF);
        chk("ldff_ret", 32'(OUT_RETIRED), 32'd5);
        do_sta(3, 8'hFF, 1'b1);
        chk("sta_ret", 32'(OUT_RETIRED), 32'd6);
        chk("sta_acc_kept", 32'(OUT_ACC), 32'hFF);
        chk("sta_cy_kept", 32'(OUT_CY), 32'd1);
        do_sta(0, 8'hFF, 1'b1);
        chk("sta_early_ret", 32'(OUT_RETIRED), 32'd7);

        // XOR then zero-flag sequence
        do_op(3'b100, 8'h0F);
        chk("xor_acc", 32'(OUT_ACC), 32'hF0);
        do_op(3'b110, 8'h5A);
        do_op(3'b011, 8'h00);
        chk("and_acc", 32'(OUT_ACC), 32'h00);
`ifdef ACC_CTRL_ZERO_FLAG_EN
        chk("and_z", 32'(OUT_Z), 32'd1);
`endif
        do_sta(1, 8'h00, 1'b1);
`ifdef ACC_CTRL_ZERO_FLAG_EN
        chk("sta_z_kept", 32'(OUT_Z), 32'd1);
`endif
        do_op(3'b000, 8'h01);
        chk("add1_acc", 32'(OUT_ACC), 32'h01);
        chk("add1_cy", 32'(OUT_CY), 32'd0);
        chk("add1_ret", 32'(OUT_RETIRED), 32'd12);
`ifdef ACC_CTRL_ZERO_FLAG_EN
        chk("add1_z", 32'(OUT_Z), 32'd0);
`endif

        // Reset while a store is pending
        @(negedge CLK);
        IN_ST_READY    = 1'b0;
        IN_INSTR_VALID = 1'b1;
        IN_INSTR       = {3'b111, 8'h00};
        @(negedge CLK);
        IN_INSTR_VALID = 1'b0;
        chk("pend_st_valid", 32'(OUT_ST_VALID), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        chk_reset_state("rst_store");
        release_reset();
        do_op(3'b110, 8'h33);
        chk("post_rst_acc", 32'(OUT_ACC), 32'h33);
        chk("post_rst_ret", 32'(OUT_RETIRED), 32'd1);

        // Retire counter wrap: 256 instructions from reset
        @(negedge CLK);
        RST_N = 1'b0;
        release_reset();
        for (int i = 0; i < 255; i++) begin
            do_op(3'b110, 8'(i));
        end
        chk("wrap_ret_ff", 32'(OUT_RETIRED), 32'hFF);
        chk("wrap_acc", 32'(OUT_ACC), 32'hFE);
        do_op(3'b110, 8'h77);
        chk("wrap_ret_00", 32'(OUT_RETIRED), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/acc_ctrl.md
# acc_ctrl

Accumulator control sequencer that sits in front of the 8-bit ALU. It is the initiator for the ALU's op/operand interface. It accepts instructions over a valid/ready handshake and drives the ALU opcode and operands. It registers the ALU result into the accumulator and carry flag, and emits the accumulator on a store channel with valid/ready back-pressure.

## Interface
Parameters:
- DATA_W, 8, datapath width. Instruction width is DATA_W+3.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_INSTR_VALID  in  1  instruction valid.
- IN_INSTR  in  DATA_W+3  instruction {op[2:0], imm[DATA_W-1:0]}.
- OUT_INSTR_READY  out  1  instruction accept.
- OUT_ALU_A  out  DATA_W  ALU A operand; always equals ACC.
- OUT_ALU_R  out  DATA_W  ALU R operand; the latched imm.
- OUT_ALU_OP  out  3  ALU opcode.
- IN_ALU_RES  in  DATA_W  ALU result.
- IN_ALU_CY  in  1  ALU carry/borrow.
- OUT_ST_VALID  out  1  store data valid.
- OUT_ST_DATA  out  DATA_W  stored accumulator value.
- OUT_ST_CY  out  1  carry flag captured with the store.
- IN_ST_READY  in  1  store accept.
- OUT_ACC  out  DATA_W  accumulator.
- OUT_CY  out  1  carry flag.
- OUT_RETIRED  out  8  retired-instruction count; wraps 0xFF→0x00.
- OUT_Z  out  1  zero flag. Present only with ACC_CTRL_ZERO_FLAG_EN.

## Operation
Opcodes:
- 000 ADD, 001 SUB, 010 OR, 011 AND, 100 XOR, 101 NOT and 110 LD are ALU ops.
- 111 STA is a store.

FSM states are IDLE, EXEC and STORE. Reset state is IDLE.
- **IDLE:**
  - OUT_INSTR_READY=1. It is a combinational decode of state==IDLE.
  - On a handshake, latch op and imm.
  - Next state is STORE if op==111, otherwise EXEC.
- **EXEC:**
  - OUT_ALU_OP=latched op and OUT_ALU_R=imm.
  - At the clock edge: ACC←IN_ALU_RES and OUT_RETIRED+1.
  - CY←IN_ALU_CY only for ADD and SUB. All other ops preserve CY.
  - Next state is IDLE.
- **STORE:**
  - OUT_ST_VALID=1, OUT_ST_DATA=ACC, OUT_ST_CY=CY.
  - These outputs are stable until IN_ST_READY=1 is sampled.
  - On that edge: OUT_RETIRED+1, next state is IDLE.
  - ACC and CY are unchanged.
- **Outside EXEC:**
  - OUT_ALU_OP=3'b111, for which the ALU outputs 0.
  - OUT_ALU_R holds the last imm.
- **Arithmetic:**
  - The ALU forms {CY,RES}=A±R in DATA_W+1 bits.
  - SUB borrow appears as CY=1.
  - The sequencer does not recompute anything and trusts IN_ALU_*.
- IN_INSTR and IN_INSTR_VALID are ignored outside IDLE. They may change freely.

## Timing
- **Reset:**
  - Asynchronous assert forces IDLE immediately.
  - ACC=0, CY=0, OUT_RETIRED=0, imm=0, OUT_ST_VALID=0, OUT_ALU_OP=111, OUT_Z=0.
  - OUT_INSTR_READY=1 once RST_N is high.
  - Reset mid-EXEC drops the writeback. Reset mid-STORE drops valid with no handshake.
- **ALU-op latency:**
  - The instruction is accepted at edge n.
  - ACC/CY are updated at edge n+1.
  - OUT_INSTR_READY is high again during cycle n+1→n+2.
  - Throughput is one ALU op per 2 cycles.
- **STA latency:**
  - OUT_ST_VALID rises the cycle after the instruction is accepted.
  - Minimum 2 cycles per STA. Each cycle of IN_ST_READY=0 adds one cycle.
- **Ordering:** STA after an ALU op returns the updated ACC. No hazard is possible because of the single-issue FSM.
- **Handshake rules:**
  - IN_ST_READY may be high before valid rises.
  - The transfer occurs on the first edge where both are high.

## Configuration
- **ACC_CTRL_ZERO_FLAG_EN defined:**
  - Port OUT_Z exists.
  - Z←(IN_ALU_RES==0) at every EXEC writeback, for all ops including LD.
  - STA preserves Z. Reset value is 0.
- **ACC_CTRL_ZERO_FLAG_EN undefined:** the port and register are absent. All other behaviour is identical.

## Test plan
- **Reset:** Assert RST_N=0 mid-run → ACC=0x00, CY=0, OUT_RETIRED=0, OUT_ALU_OP=111, OUT_ST_VALID=0. After release, OUT_INSTR_READY=1.
- **Add with carry:** LD 0xF0 then ADD 0x20 → ACC=0x10, CY=1, OUT_RETIRED=2. OUT_ALU_OP=000 appears for exactly one cycle.
- **Sub borrow and CY preservation:** LD 0x05, SUB 0x06 → ACC=0xFF, CY=1. Then OR 0x00 → ACC=0xFF, CY still 1. Then NOT → ACC=0x00, CY=1.
- **Store back-pressure:**
  - Setup: ACC=0xFF; issue STA with IN_ST_READY=0 for 3 cycles.
  - Response: OUT_ST_VALID=1 with OUT_ST_DATA=0xFF and OUT_ST_CY=1 stable. OUT_INSTR_READY=0.
  - Raise ready: one transfer, OUT_RETIRED increments once, and IDLE follows.
- **Reset during STORE:** STA pending with ready low, then RST_N=0 → OUT_ST_VALID falls immediately, ACC=0. After release, the next instruction is accepted normally.
- **Zero flag and counter wrap (macro on):**
  - LD 0x5A, AND 0x00 → OUT_Z=1.
  - ADD 0x01 → OUT_Z=0.
  - 256 instructions from reset → OUT_RETIRED=0x00.
